// File: rtl/field_cfg_loader_pkg.sv
// Shared types for the field configuration loader.
// Optional feature macro: FIELD_CFG_LOADER_CLEAR_FIRST_EN adds the CLEAR state.
package defs;

  // Configuration requested by the config-load controller.
  typedef enum logic {
    NO_REQ = 1'b0,
    CFG_1  = 1'b1
  } load_cfg_req_t;

  // Loader sequencing states; CLEAR only exists when the clear-first feature is built.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2
`ifdef FIELD_CFG_LOADER_CLEAR_FIRST_EN
    ,
    CLEAR = 2'd3
`endif
  } loader_state_t;

  // A request is worth loading only if it names an actual pattern.
  function automatic logic is_valid_req(input load_cfg_req_t req);
    return req != NO_REQ;
  endfunction

endpackage

// File: rtl/field_cfg_loader_if.sv
// Bus between the config-load controller and the loader, including the
// field-memory row write port the loader drives.
interface field_cfg_loader_if
  import defs::*;
#(
  parameter int FIELD_W = 32,
  parameter int FIELD_H = 32
) ();

  logic                       i_go;
  load_cfg_req_t              i_cfg_req;
  logic                       o_is_loading;
  logic                       o_wr_en;
  logic [$clog2(FIELD_H)-1:0] o_wr_addr;
  logic [FIELD_W-1:0]         o_wr_data;
  logic                       o_done;

  // Controller side: issues the load strobe and watches progress.
  modport master (
    output i_go,
    output i_cfg_req,
    input  o_is_loading,
    input  o_wr_en,
    input  o_wr_addr,
    input  o_wr_data,
    input  o_done
  );

  // Loader side.
  modport slave (
    input  i_go,
    input  i_cfg_req,
    output o_is_loading,
    output o_wr_en,
    output o_wr_addr,
    output o_wr_data,
    output o_done
  );

endinterface

// File: rtl/field_cfg_loader_cfg_rom.sv
// Combinational pattern lookup: returns one row of the selected start pattern.
// Bit 0 of the returned row is the leftmost column.
module cfg_rom
  import defs::*;
#(
  parameter int FIELD_W = 32,
  parameter int FIELD_H = 32
) (
  input  load_cfg_req_t               cfg,
  input  logic [$clog2(FIELD_H)-1:0]  row,
  output logic [FIELD_W-1:0]          data
);

  localparam int AW = $clog2(FIELD_H);

  // Glider occupies the top-left corner; everything else in the field is empty.
  always_comb begin
    data = '0;
    unique case (cfg)
      CFG_1: begin
        if (row == AW'(0)) begin
          data[1] = 1'b1;
        end else if (row == AW'(1)) begin
          data[2] = 1'b1;
        end else if (row == AW'(2)) begin
          data[2:0] = 3'b111;
        end
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/field_cfg_loader.sv
// Field configuration loader: on an accepted load strobe, writes every row of
// the field memory with the selected start pattern, then pulses o_done.
// Optional feature macro: FIELD_CFG_LOADER_CLEAR_FIRST_EN -- when defined, the
// whole field is first written with zero rows (CLEAR) before the pattern load.
module field_cfg_loader
  import defs::*;
#(
  parameter int FIELD_W = 32,
  parameter int FIELD_H = 32
) (
  input  logic                clk,
  input  logic                rst,
  field_cfg_loader_if.slave   bus
);

  localparam int              AW       = $clog2(FIELD_H);
  localparam logic [AW-1:0]   LAST_ROW = AW'(FIELD_H - 1);

  loader_state_t      state_q, state_d;
  logic [AW-1:0]      row_q, row_d;
  load_cfg_req_t      cfg_q, cfg_d;

  logic               loading_q, loading_d;
  logic               wr_en_q, wr_en_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic [FIELD_W-1:0] wr_data_q, wr_data_d;
  logic               done_q, done_d;

  logic [FIELD_W-1:0] rom_data;

  // The ROM is looked up with the next-cycle row/config so the write data can
  // be registered alongside the address and enable.
  cfg_rom #(
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H)
  ) u_cfg_rom (
    .cfg  (cfg_d),
    .row  (row_d),
    .data (rom_data)
  );

  // Next-state sequencing, and the outputs that the next state will present.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cfg_d   = cfg_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_go && is_valid_req(bus.i_cfg_req)) begin
          cfg_d = bus.i_cfg_req;
          row_d = '0;
`ifdef FIELD_CFG_LOADER_CLEAR_FIRST_EN
          state_d = CLEAR;
`else
          state_d = LOAD;
`endif
        end
      end
`ifdef FIELD_CFG_LOADER_CLEAR_FIRST_EN
      CLEAR: begin
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = LOAD;
        end else begin
          row_d = row_q + AW'(1);
        end
      end
`endif
      LOAD: begin
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = DONE;
        end else begin
          row_d = row_q + AW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
      end
    endcase

    loading_d = (state_d != IDLE);
    done_d    = (state_d == DONE);
`ifdef FIELD_CFG_LOADER_CLEAR_FIRST_EN
    wr_en_d   = (state_d == LOAD) || (state_d == CLEAR);
`else
    wr_en_d   = (state_d == LOAD);
`endif
    wr_addr_d = wr_en_d ? row_d : '0;
    wr_data_d = (state_d == LOAD) ? rom_data : '0;
  end

  // State, row counter, latched config and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      cfg_q     <= NO_REQ;
      loading_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cfg_q     <= cfg_d;
      loading_q <= loading_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_is_loading = loading_q;
  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_wr_data    = wr_data_q;
  assign bus.o_done       = done_q;

endmodule

// File: tb/tb_field_cfg_loader.sv
// Self-checking bench for field_cfg_loader (FIELD_W=8, FIELD_H=8).
// Honors FIELD_CFG_LOADER_CLEAR_FIRST_EN when the build defines it.
module tb_field_cfg_loader;
  import defs::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = $clog2(H);
`ifdef FIELD_CFG_LOADER_CLEAR_FIRST_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif
  // Phase numbering after an accepted strobe: 1..H*(1+CLR) are writes, the last is o_done.
  localparam int LAST_T = H * (1 + CLR) + 1;

  typedef struct {
    logic          rst;
    logic          go;
    load_cfg_req_t req;
    logic          loading;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  field_cfg_loader_if #(.FIELD_W(W), .FIELD_H(H)) bus ();

  field_cfg_loader #(.FIELD_W(W), .FIELD_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int t_model = 0;

  // Glider rows from the pattern definition.
  function automatic logic [W-1:0] glider(input int r);
    logic [W-1:0] v;
    v = '0;
    if (r == 0) v = 8'h02;
    else if (r == 1) v = 8'h04;
    else if (r == 2) v = 8'h07;
    return v;
  endfunction

  // Reference model: advance the load phase counter at a rising edge.
  task automatic model_step();
    if (rst) t_model = 0;
    else if (t_model == 0) begin
      if (bus.i_go && bus.i_cfg_req == CFG_1) t_model = 1;
    end else if (t_model == LAST_T) t_model = 0;
    else t_model = t_model + 1;
  endtask

  // Reference model: outputs expected in the current phase.
  task automatic model_expect(output logic l, output logic we, output logic [AW-1:0] a,
                              output logic [W-1:0] d, output logic dn);
    int r;
    l = (t_model != 0); we = 1'b0; a = '0; d = '0; dn = 1'b0;
    if (t_model == LAST_T) dn = 1'b1;
    else if (t_model != 0 && t_model <= CLR * H) begin
      we = 1'b1; a = AW'(t_model - 1);
    end else if (t_model != 0) begin
      r = t_model - 1 - CLR * H;
      we = 1'b1; a = AW'(r); d = glider(r);
    end
  endtask

  task automatic check_one(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic l, input logic we,
                              input logic [AW-1:0] a, input logic [W-1:0] d, input logic dn);
    check_one({tag, ".o_is_loading"}, 32'(bus.o_is_loading), 32'(l));
    check_one({tag, ".o_wr_en"},      32'(bus.o_wr_en),      32'(we));
    check_one({tag, ".o_wr_addr"},    32'(bus.o_wr_addr),    32'(a));
    check_one({tag, ".o_wr_data"},    32'(bus.o_wr_data),    32'(d));
    check_one({tag, ".o_done"},       32'(bus.o_done),       32'(dn));
  endtask

  task automatic check_model(input string tag);
    logic l, we, dn;
    logic [AW-1:0] a;
    logic [W-1:0] d;
    model_expect(l, we, a, d, dn);
    check_output(tag, l, we, a, d, dn);
  endtask

  // Drive inputs for one edge, step the model, then settle at the falling edge.
  task automatic apply_stimulus(input logic r, input logic g, input load_cfg_req_t q);
    rst = r;
    bus.i_go = g;
    bus.i_cfg_req = q;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic add_vec(ref vec_t vq[$], input logic r, input logic g, input load_cfg_req_t q,
                         input logic l, input logic we, input int a, input int d, input logic dn);
    vec_t v;
    v.rst = r; v.go = g; v.req = q; v.loading = l; v.wr_en = we;
    v.addr = AW'(a); v.data = W'(d); v.done = dn;
    vq.push_back(v);
  endtask

  initial begin
    vec_t vecs[$];
    int   n_wr;
    int   n_done;
    int   pat [8];

    bus.i_go = 1'b0;
    bus.i_cfg_req = NO_REQ;
    rst = 1'b1;

    // Directed load of CFG_1 from reset, expectations written out by hand.
    pat = '{8'h02, 8'h04, 8'h07, 0, 0, 0, 0, 0};
    add_vec(vecs, 1, 0, NO_REQ, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add_vec(vecs, 0, 0, NO_REQ, 0, 0, 0, 0, 0);
    if (CLR != 0) begin
      add_vec(vecs, 0, 1, CFG_1, 1, 1, 0, 0, 0);
      for (int i = 1; i < H; i++) add_vec(vecs, 0, 0, NO_REQ, 1, 1, i, 0, 0);
      for (int i = 0; i < H; i++) add_vec(vecs, 0, 0, NO_REQ, 1, 1, i, pat[i], 0);
    end else begin
      add_vec(vecs, 0, 1, CFG_1, 1, 1, 0, pat[0], 0);
      for (int i = 1; i < H; i++) add_vec(vecs, 0, 0, NO_REQ, 1, 1, i, pat[i], 0);
    end
    add_vec(vecs, 0, 0, NO_REQ, 1, 0, 0, 0, 1);
    add_vec(vecs, 0, 0, NO_REQ, 0, 0, 0, 0, 0);
    add_vec(vecs, 0, 0, NO_REQ, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst, vecs[i].go, vecs[i].req);
      check_output($sformatf("vec%0d", i), vecs[i].loading, vecs[i].wr_en,
                   vecs[i].addr, vecs[i].data, vecs[i].done);
    end

    // NO_REQ strobe is ignored.
    apply_stimulus(0, 1, NO_REQ);
    check_model("noreq_go");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, NO_REQ);
      check_one("noreq_loading", 32'(bus.o_is_loading), 32'(0));
    end

    // Second strobe during write 3 is ignored: one full load, one done pulse.
    apply_stimulus(0, 1, CFG_1);
    check_model("midgo_start");
    n_wr = int'(bus.o_wr_en);
    n_done = int'(bus.o_done);
    for (int k = 1; k <= LAST_T + 2; k++) begin
      apply_stimulus(0, (k == CLR * H + 4), CFG_1);
      check_model($sformatf("midgo_k%0d", k));
      n_wr += int'(bus.o_wr_en);
      n_done += int'(bus.o_done);
    end
    check_one("midgo_writes", 32'(n_wr), 32'(H * (1 + CLR)));
    check_one("midgo_dones", 32'(n_done), 32'(1));

    // Reset during write 4 stops the load without a done pulse.
    apply_stimulus(0, 1, CFG_1);
    for (int k = 1; k < CLR * H + 5; k++) apply_stimulus(0, 0, NO_REQ);
    check_one("rst_at_addr4", 32'(bus.o_wr_addr), 32'(4));
    apply_stimulus(1, 0, NO_REQ);
    check_model("rst_mid");
    n_wr = 0;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, NO_REQ);
      n_wr += int'(bus.o_wr_en);
      n_done += int'(bus.o_done);
    end
    check_one("rst_writes_after", 32'(n_wr), 32'(0));
    check_one("rst_dones_after", 32'(n_done), 32'(0));
    apply_stimulus(0, 1, CFG_1);
    check_one("restart_wr_en", 32'(bus.o_wr_en), 32'(1));
    check_one("restart_addr", 32'(bus.o_wr_addr), 32'(0));
    for (int k = 1; k <= LAST_T; k++) begin
      apply_stimulus(0, 0, NO_REQ);
      check_model($sformatf("restart_k%0d", k));
    end

    // Random strobes, configs and occasional resets against the model.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(39) == 0), ($urandom_range(5) == 0),
                     load_cfg_req_t'($urandom_range(1)));
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
